// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I-cache / D-cache memory arbiter:
// default widths, FSM state encoding and grant identifiers.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int LINE_W_DEF = 128;

  // FSM state encoding, kept as plain constants for older tools
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SERVE_I = 3'd1;
  localparam logic [2:0] ST_SERVE_D = 3'd2;
  localparam logic [2:0] ST_DONE_I  = 3'd3;
  localparam logic [2:0] ST_DONE_D  = 3'd4;

  // Identity of the requester granted most recently
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port line memory.
// The I-cache issues line reads, the D-cache issues line reads and
// write-backs. Ties are broken by alternating against the last grant.
// The memory command is registered at grant and held until mem_ready.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              Clk,
  input  logic              rst,
  // I-cache side
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_ready,
  // D-cache side
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_ready,
  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  logic [2:0] state;
  logic       last_grant;
  logic       d_req;
  logic       pick_d;

  // D wants service for either a read or a write-back; when both caches
  // ask at once, D wins only if I was the one served last.
  assign d_req  = dc_read | dc_write;
  assign pick_d = d_req & (~ic_read | (last_grant == GRANT_I));

  // FSM, grant bookkeeping, memory command registers and returned-line
  // capture all live in one block so they change together on each edge.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= GRANT_I;
      ic_ready   <= 1'b0;
      dc_ready   <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ic_rdata   <= '0;
      dc_rdata   <= '0;
    end else begin
      ic_ready <= 1'b0;
      dc_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_d) begin
            state      <= ST_SERVE_D;
            last_grant <= GRANT_D;
            mem_addr   <= dc_addr;
            mem_write  <= dc_write;
            mem_read   <= ~dc_write;
            if (dc_write) begin
              mem_wdata <= dc_wdata;
            end
          end else if (ic_read) begin
            state      <= ST_SERVE_I;
            last_grant <= GRANT_I;
            mem_addr   <= ic_addr;
            mem_read   <= 1'b1;
            mem_write  <= 1'b0;
          end
        end
        ST_SERVE_I: begin
          if (mem_ready) begin
            ic_rdata  <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ic_ready  <= 1'b1;
            state     <= ST_DONE_I;
          end
        end
        ST_SERVE_D: begin
          if (mem_ready) begin
            // a write-back returns no line, so the last read line stays
            if (mem_read) begin
              dc_rdata <= mem_rdata;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            dc_ready  <= 1'b1;
            state     <= ST_DONE_D;
          end
        end
        ST_DONE_I, ST_DONE_D: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-programmable line memory
// model and a completion scoreboard.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int LW = 128;
  localparam logic [LW-1:0] DEAD = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  logic          Clk = 1'b0;
  logic          rst = 1'b0;
  logic          ic_read = 1'b0;
  logic [AW-1:0] ic_addr = '0;
  logic [LW-1:0] ic_rdata;
  logic          ic_ready;
  logic          dc_read = 1'b0;
  logic          dc_write = 1'b0;
  logic [AW-1:0] dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0;
  logic [LW-1:0] dc_rdata;
  logic          dc_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata = '0;
  logic          mem_ready;

  logic          model_ready = 1'b0;
  logic          spur_ready = 1'b0;
  int            lat = 5;
  int            cnt = 0;
  logic [LW-1:0] mem [32];

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit            is_d;
    logic [LW-1:0] data;
  } exp_t;
  exp_t sb[$];

  assign mem_ready = model_ready | spur_ready;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .Clk(Clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // free-running clock, period 10
  always #5 Clk = ~Clk;

  // memory preload: line i holds four copies of 0xA5A500ii
  initial begin
    for (int i = 0; i < 32; i++) mem[i] <= {4{32'hA5A50000 | 32'(i)}};
  end

  // line memory: answers a held command after lat cycles with a one-cycle mem_ready
  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      model_ready <= 1'b0;
      cnt         <= 0;
    end else if (model_ready) begin
      model_ready <= 1'b0;
      cnt         <= 0;
    end else if (mem_read || mem_write) begin
      if (cnt + 1 == lat) begin
        model_ready <= 1'b1;
        cnt         <= 0;
        if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
        else           mem_rdata <= mem[mem_addr[4:0]];
      end else begin
        cnt <= cnt + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic popCheck(input bit is_d, input logic [LW-1:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput(is_d ? "dc_ready unexpected" : "ic_ready unexpected", LW'(1), LW'(0));
    end else begin
      e = sb.pop_front();
      checkOutput("completion requester", LW'(is_d), LW'(e.is_d));
      checkOutput(is_d ? "dc_rdata" : "ic_rdata", data, e.data);
    end
  endtask

  // monitor: every ready pulse must match the oldest expected completion
  always @(negedge Clk) begin
    if (ic_ready) popCheck(1'b0, ic_rdata);
    if (dc_ready) popCheck(1'b1, dc_rdata);
  end

  task automatic expectDone(input bit is_d, input logic [LW-1:0] data);
    exp_t e;
    e.is_d = is_d;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [AW-1:0] da, input logic [LW-1:0] dwd);
    ic_read  = ir;
    ic_addr  = ia;
    dc_read  = dr;
    dc_write = dw;
    dc_addr  = da;
    dc_wdata = dwd;
  endtask

  task automatic waitReady(input bit is_d, input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(negedge Clk);
      n++;
      seen = is_d ? dc_ready : ic_ready;
    end
    if (is_d) begin
      dc_read  = 1'b0;
      dc_write = 1'b0;
    end else begin
      ic_read = 1'b0;
    end
    checkOutput(is_d ? "dc_ready within budget" : "ic_ready within budget",
                LW'(seen), LW'(1));
  endtask

  task automatic doReset();
    @(negedge Clk);
    rst = 1'b1;
    @(negedge Clk);
    rst = 1'b0;
  endtask

  initial begin
    // asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    checkOutput("reset mem_read", LW'(mem_read), LW'(0));
    checkOutput("reset mem_write", LW'(mem_write), LW'(0));
    checkOutput("reset ic_ready", LW'(ic_ready), LW'(0));
    checkOutput("reset dc_ready", LW'(dc_ready), LW'(0));
    checkOutput("reset ic_rdata", ic_rdata, LW'(0));
    @(negedge Clk);
    rst = 1'b0;

    // single I read, latency 5: mem_read cycles 1..6, ic_ready in cycle 7
    lat = 5;
    @(negedge Clk);
    expectDone(1'b0, {4{32'hA5A50010}});
    applyStimulus(1'b1, 28'h10, 1'b0, 1'b0, '0, '0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge Clk);
      checkOutput($sformatf("mem_read cycle %0d", c), LW'(mem_read), LW'(c <= 6));
      checkOutput($sformatf("ic_ready cycle %0d", c), LW'(ic_ready), LW'(c == 7));
      checkOutput($sformatf("dc_ready cycle %0d", c), LW'(dc_ready), LW'(0));
      if (c == 1) checkOutput("single read mem_addr", LW'(mem_addr), LW'(28'h10));
    end
    ic_read = 1'b0;

    // tie straight after reset: D first, then I, twice
    doReset();
    lat = 2;
    expectDone(1'b1, {4{32'hA5A50005}});
    expectDone(1'b0, {4{32'hA5A50003}});
    applyStimulus(1'b1, 28'h3, 1'b1, 1'b0, 28'h5, '0);
    @(negedge Clk);
    checkOutput("tie1 first grant addr", LW'(mem_addr), LW'(28'h5));
    fork
      waitReady(1'b1, 100);
      waitReady(1'b0, 100);
    join
    @(negedge Clk);
    expectDone(1'b1, {4{32'hA5A50007}});
    expectDone(1'b0, {4{32'hA5A50008}});
    applyStimulus(1'b1, 28'h8, 1'b1, 1'b0, 28'h7, '0);
    fork
      waitReady(1'b1, 100);
      waitReady(1'b0, 100);
    join

    // after a D-only grant, a tie goes to I
    @(negedge Clk);
    expectDone(1'b1, {4{32'hA5A5000C}});
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'hC, '0);
    waitReady(1'b1, 100);
    @(negedge Clk);
    expectDone(1'b0, {4{32'hA5A5000D}});
    expectDone(1'b1, {4{32'hA5A5000E}});
    applyStimulus(1'b1, 28'hD, 1'b1, 1'b0, 28'hE, '0);
    @(negedge Clk);
    checkOutput("tie3 first grant addr", LW'(mem_addr), LW'(28'hD));
    fork
      waitReady(1'b1, 100);
      waitReady(1'b0, 100);
    join

    // read and write together: write wins, dc_rdata keeps the last read line
    @(negedge Clk);
    lat = 3;
    expectDone(1'b1, {4{32'hA5A5000E}});
    applyStimulus(1'b0, '0, 1'b1, 1'b1, 28'h9, DEAD);
    @(negedge Clk);
    checkOutput("write mem_write", LW'(mem_write), LW'(1));
    checkOutput("write mem_read", LW'(mem_read), LW'(0));
    checkOutput("write mem_wdata", mem_wdata, DEAD);
    checkOutput("write mem_addr", LW'(mem_addr), LW'(28'h9));
    waitReady(1'b1, 100);
    checkOutput("memory line 9 updated", mem[9], DEAD);
    @(negedge Clk);
    expectDone(1'b1, DEAD);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'h9, '0);
    waitReady(1'b1, 100);

    // dc_addr/dc_wdata wander during SERVE_D; the memory command must not
    @(negedge Clk);
    lat = 4;
    expectDone(1'b1, {4{32'hA5A5000A}});
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'hA, '0);
    @(negedge Clk);
    checkOutput("hold mem_addr at grant", LW'(mem_addr), LW'(28'hA));
    for (int k = 0; k < 3; k++) begin
      dc_addr  = 28'h1F - AW'(k);
      dc_wdata = DEAD;
      @(negedge Clk);
      checkOutput($sformatf("hold mem_addr %0d", k), LW'(mem_addr), LW'(28'hA));
      checkOutput($sformatf("hold mem_read %0d", k), LW'(mem_read), LW'(1));
    end
    waitReady(1'b1, 100);

    // reset two cycles into SERVE_I: outputs clear at once, no ic_ready
    @(negedge Clk);
    lat = 10;
    applyStimulus(1'b1, 28'h11, 1'b0, 1'b0, '0, '0);
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midreset mem_read", LW'(mem_read), LW'(0));
    checkOutput("midreset mem_write", LW'(mem_write), LW'(0));
    checkOutput("midreset mem_addr", LW'(mem_addr), LW'(0));
    checkOutput("midreset mem_wdata", mem_wdata, LW'(0));
    checkOutput("midreset ic_rdata", ic_rdata, LW'(0));
    checkOutput("midreset dc_rdata", dc_rdata, LW'(0));
    checkOutput("midreset ic_ready", LW'(ic_ready), LW'(0));
    checkOutput("midreset dc_ready", LW'(dc_ready), LW'(0));
    @(negedge Clk);
    rst = 1'b0;
    expectDone(1'b0, {4{32'hA5A50011}});
    @(negedge Clk);
    checkOutput("regrant mem_read", LW'(mem_read), LW'(1));
    checkOutput("regrant mem_addr", LW'(mem_addr), LW'(28'h11));
    waitReady(1'b0, 100);

    // spurious mem_ready in IDLE is ignored
    @(negedge Clk);
    @(negedge Clk);
    spur_ready = 1'b1;
    @(negedge Clk);
    spur_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("spurious ic_ready %0d", k), LW'(ic_ready), LW'(0));
      checkOutput($sformatf("spurious dc_ready %0d", k), LW'(dc_ready), LW'(0));
      checkOutput($sformatf("spurious mem_read %0d", k), LW'(mem_read), LW'(0));
      checkOutput($sformatf("spurious mem_write %0d", k), LW'(mem_write), LW'(0));
      @(negedge Clk);
    end
    checkOutput("spurious ic_rdata held", ic_rdata, {4{32'hA5A50011}});
    lat = 1;
    expectDone(1'b0, {4{32'hA5A50012}});
    applyStimulus(1'b1, 28'h12, 1'b0, 1'b0, '0, '0);
    waitReady(1'b0, 100);

    @(negedge Clk);
    @(negedge Clk);
    checkOutput("scoreboard drained", LW'(sb.size()), LW'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog in case a stimulus step stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
